// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan driver: hex glyph table and blank pattern.
// Segment order is {a,b,c,d,e,f,g}, active-low.
package ssd_pkg;

    localparam logic [6:0] SEG_HEX [16] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

    localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational nibble to active-low seven-segment pattern.
module ssd_hex_decoder
    import ssd_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg_n
);

    assign o_seg_n = SEG_HEX[i_nibble];

endmodule

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed seven-segment driver: frame-snapshotted digits, leading-zero blanking,
// per-digit enable, decimal points and PWM brightness, with registered anode/cathode outputs.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 8,
    parameter int unsigned SCAN_DIV_BITS = 18,
    parameter int unsigned PWM_BITS      = 4
) (
    input  logic                          ClkPort,
    input  logic                          Reset,
    input  logic [4*NUM_DIGITS-1:0]       value,
    input  logic [NUM_DIGITS-1:0]         dp_en,
    input  logic [NUM_DIGITS-1:0]         digit_en,
    input  logic                          blank_lz,
    input  logic [PWM_BITS-1:0]           brightness,
    output logic [NUM_DIGITS-1:0]         anode_n,
    output logic [7:0]                    cathode_n,
    output logic [$clog2(NUM_DIGITS)-1:0] scan_idx,
    output logic                          frame_tick
);

    localparam int unsigned IdxW = $clog2(NUM_DIGITS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);

    logic [SCAN_DIV_BITS-1:0] r_presc;
    logic [IdxW-1:0]          r_idx;
    logic                     r_frame_tick;
    logic [4*NUM_DIGITS-1:0]  r_snap_value;
    logic [NUM_DIGITS-1:0]    r_snap_dp;
    logic [NUM_DIGITS-1:0]    r_snap_en;
    logic                     r_snap_blank_lz;
    logic [NUM_DIGITS-1:0]    r_anode_n;
    logic [7:0]               r_cathode_n;

    logic                     w_advance;
    logic                     w_wrap;
    logic [IdxW-1:0]          w_idx_next;
    logic [NUM_DIGITS-1:0]    w_lz_blank;
    logic [3:0]               w_nibble;
    logic [6:0]               w_seg_n;
    logic [PWM_BITS-1:0]      w_pwm_phase;
    logic                     w_pwm_on;
    logic                     w_active;
    logic [NUM_DIGITS-1:0]    w_anode_n;
    logic [7:0]               w_cathode_n;

    assign w_advance  = &r_presc;
    assign w_wrap     = w_advance && (r_idx == LastIdx);
    assign w_idx_next = (r_idx == LastIdx) ? '0 : r_idx + 1'b1;

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            r_presc      <= '0;
            r_idx        <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_presc      <= r_presc + 1'b1;
            r_frame_tick <= w_wrap;
            if (w_advance) begin
                r_idx <= w_idx_next;
            end
        end
    end

    // Snapshot only at frame wrap so a mid-scan value change cannot tear the display.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            r_snap_value    <= '0;
            r_snap_dp       <= '0;
            r_snap_en       <= '0;
            r_snap_blank_lz <= 1'b0;
        end else if (w_wrap) begin
            r_snap_value    <= value;
            r_snap_dp       <= dp_en;
            r_snap_en       <= digit_en;
            r_snap_blank_lz <= blank_lz;
        end
    end

    // Walk down from the top digit; a digit is blanked while everything above it is zero too.
    always_comb begin
        logic run_zero;
        w_lz_blank = '0;
        run_zero   = r_snap_blank_lz;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            run_zero      = run_zero && (r_snap_value[4*i +: 4] == 4'h0);
            w_lz_blank[i] = run_zero;
        end
    end

    assign w_nibble = r_snap_value[{r_idx, 2'b00} +: 4];

    ssd_hex_decoder u_hex_decoder (
        .i_nibble (w_nibble),
        .o_seg_n  (w_seg_n)
    );

    assign w_pwm_phase = r_presc[SCAN_DIV_BITS-1 -: PWM_BITS];
    assign w_pwm_on    = (&brightness) || (w_pwm_phase < brightness);
    assign w_active    = r_snap_en[r_idx] && !w_lz_blank[r_idx] && w_pwm_on;

    always_comb begin
        w_anode_n   = '1;
        w_cathode_n = SEG_BLANK;
        if (w_active) begin
            w_anode_n   = ~(NUM_DIGITS'(1) << r_idx);
            w_cathode_n = {w_seg_n, ~r_snap_dp[r_idx]};
        end
    end

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            r_anode_n   <= '1;
            r_cathode_n <= SEG_BLANK;
        end else begin
            r_anode_n   <= w_anode_n;
            r_cathode_n <= w_cathode_n;
        end
    end

    assign anode_n    = r_anode_n;
    assign cathode_n  = r_cathode_n;
    assign scan_idx   = r_idx;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver with 4 digits, 16-clock digit slots and 2-bit PWM.
module tb_ssd_scan_driver;

    logic        ClkPort = 1'b0;
    logic        Reset   = 1'b1;
    logic [15:0] value   = 16'h12AF;
    logic [3:0]  dp_en   = 4'b0000;
    logic [3:0]  digit_en = 4'b1111;
    logic        blank_lz = 1'b0;
    logic [1:0]  brightness = 2'd3;
    logic [3:0]  anode_n;
    logic [7:0]  cathode_n;
    logic [1:0]  scan_idx;
    logic        frame_tick;

    int n_vec  = 0;
    int n_fail = 0;
    int k      = 0;

    always #5 ClkPort = ~ClkPort;

    ssd_scan_driver #(
        .NUM_DIGITS    (4),
        .SCAN_DIV_BITS (4),
        .PWM_BITS      (2)
    ) dut (
        .ClkPort    (ClkPort),
        .Reset      (Reset),
        .value      (value),
        .dp_en      (dp_en),
        .digit_en   (digit_en),
        .blank_lz   (blank_lz),
        .brightness (brightness),
        .anode_n    (anode_n),
        .cathode_n  (cathode_n),
        .scan_idx   (scan_idx),
        .frame_tick (frame_tick)
    );

    typedef struct {
        int          k;
        logic [3:0]  an;
        logic [7:0]  ca;
        logic [1:0]  idx;
        logic        tick;
        logic        ld;
        logic [15:0] val;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic        blz;
        logic [1:0]  br;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int at, input logic [7:0] act,
                       input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at k=%0d: got %b, expected %b", name, at, act, exp);
        end
    endtask

    task automatic chk_all(input int at, input logic [3:0] an, input logic [7:0] ca,
                           input logic [1:0] idx, input logic tick);
        chk("anode_n", at, {4'b0, anode_n}, {4'b0, an});
        chk("cathode_n", at, cathode_n, ca);
        chk("scan_idx", at, {6'b0, scan_idx}, {6'b0, idx});
        chk("frame_tick", at, {7'b0, frame_tick}, {7'b0, tick});
    endtask

    // Sample 2 time units after edge k (edges counted from reset release).
    task automatic run_to(input int target);
        while (k < target) begin
            @(posedge ClkPort);
            k++;
        end
        #2;
    endtask

    function automatic void add(input int kk, input logic [3:0] an, input logic [7:0] ca,
                                input logic [1:0] idx, input logic tick, input logic ld,
                                input logic [15:0] val, input logic [3:0] dp,
                                input logic [3:0] en, input logic blz, input logic [1:0] br);
        vecs.push_back('{kk, an, ca, idx, tick, ld, val, dp, en, blz, br});
    endfunction

    initial begin
        // Frame 1 dark (snapshot cleared), then 12AF with DPs off.
        add(0,   4'hF, 8'hFF,        2'd0, 1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0, 2'd0);
        add(10,  4'hF, 8'hFF,        2'd0, 1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0, 2'd0);
        add(63,  4'hF, 8'hFF,        2'd3, 1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0, 2'd0);
        add(64,  4'hF, 8'hFF,        2'd0, 1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0, 2'd0);
        add(65,  4'hE, 8'b01110001,  2'd0, 1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0, 2'd0);
        add(80,  4'hE, 8'b01110001,  2'd1, 1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0, 2'd0);
        add(81,  4'hD, 8'b00010001,  2'd1, 1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0, 2'd0);
        add(97,  4'hB, 8'b00100101,  2'd2, 1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0, 2'd0);
        add(113, 4'h7, 8'b10011111,  2'd3, 1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0, 2'd0);
        // Change inputs mid-scan: 0050 with LZ blanking and DP on digit 1.
        add(128, 4'h7, 8'b10011111,  2'd0, 1'b1, 1'b1, 16'h0050, 4'b0010, 4'hF, 1'b1, 2'd3);
        add(129, 4'hE, 8'b01110001,  2'd0, 1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0, 2'd0);
        add(177, 4'h7, 8'b10011111,  2'd3, 1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0, 2'd0);
        add(192, 4'h7, 8'b10011111,  2'd0, 1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0, 2'd0);
        add(193, 4'hE, 8'b00000011,  2'd0, 1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0, 2'd0);
        add(209, 4'hD, 8'b01001000,  2'd1, 1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0, 2'd0);
        add(225, 4'hF, 8'hFF,        2'd2, 1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0, 2'd0);
        add(241, 4'hF, 8'hFF,        2'd3, 1'b0, 1'b1, 16'h0050, 4'b0010, 4'hF, 1'b1, 2'd1);
        // Brightness 1: slot phases 0..3 lit only.
        add(257, 4'hE, 8'b00000011,  2'd0, 1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0, 2'd0);
        add(260, 4'hE, 8'b00000011,  2'd0, 1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0, 2'd0);
        add(261, 4'hF, 8'hFF,        2'd0, 1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0, 2'd0);
        add(276, 4'hD, 8'b01001000,  2'd1, 1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0, 2'd0);
        add(277, 4'hF, 8'hFF,        2'd1, 1'b0, 1'b1, 16'h0850, 4'b0010, 4'b1110, 1'b1, 2'd0);
        // Brightness 0 keeps everything dark; digit 0 disabled from this frame on.
        add(321, 4'hF, 8'hFF,        2'd0, 1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0, 2'd0);
        add(337, 4'hF, 8'hFF,        2'd1, 1'b0, 1'b1, 16'h0850, 4'b0010, 4'b1110, 1'b1, 2'd3);
        add(345, 4'hD, 8'b01001000,  2'd1, 1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0, 2'd0);
        add(353, 4'hB, 8'b00000001,  2'd2, 1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0, 2'd0);
        add(360, 4'hB, 8'b00000001,  2'd2, 1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0, 2'd0);

        repeat (3) @(posedge ClkPort);
        #2;
        Reset = 1'b0;
        k = 0;

        foreach (vecs[i]) begin
            run_to(vecs[i].k);
            chk_all(vecs[i].k, vecs[i].an, vecs[i].ca, vecs[i].idx, vecs[i].tick);
            if (vecs[i].ld) begin
                value      = vecs[i].val;
                dp_en      = vecs[i].dp;
                digit_en   = vecs[i].en;
                blank_lz   = vecs[i].blz;
                brightness = vecs[i].br;
            end
        end

        // Asynchronous reset while digit 2 is lit: outputs clear without a clock edge.
        Reset = 1'b1;
        #1;
        chk_all(-1, 4'hF, 8'hFF, 2'd0, 1'b0);
        @(posedge ClkPort);
        #2;
        chk_all(-2, 4'hF, 8'hFF, 2'd0, 1'b0);
        Reset = 1'b0;
        k = 0;

        // Restart: dark until first wrap, then snapshot 0850 with digit 0 disabled.
        run_to(63);
        chk_all(1063, 4'hF, 8'hFF, 2'd3, 1'b0);
        run_to(64);
        chk_all(1064, 4'hF, 8'hFF, 2'd0, 1'b1);
        run_to(65);
        chk_all(1065, 4'hF, 8'hFF, 2'd0, 1'b0);
        run_to(81);
        chk_all(1081, 4'hD, 8'b01001000, 2'd1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
